ex_muldiv: RTL

//  Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX register.

---
 rtl/ex_muldiv.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit sitting in the EX stage.
// It owns the architectural HI/LO registers. A multiply uses one
// shift-add step per cycle. A divide uses one restoring step per cycle.
// While an operation runs, the unit freezes the front of the pipeline.
//
// Ports
//   clk       in   1   pipeline clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   ex_busA   in   32  operand A (rs) from ID/EX
//   ex_busB   in   32  operand B (rt) from ID/EX
//   ex_aluop  in   5   operation code from ID/EX (0 for squashed slots)
//   md_flush  in   1   abort the in-flight operation / suppress a start
//   hi        out  32  HI register
//   lo        out  32  LO register
//   md_stall  out  1   freeze PC, IF/ID and ID/EX this cycle (combinational)
//   md_busy   out  1   registered: unit is iterating a multiply or divide
module ex_muldiv #(
    parameter logic [4:0] OP_MULT  = 5'd16,
    parameter logic [4:0] OP_MULTU = 5'd17,
    parameter logic [4:0] OP_DIV   = 5'd18,
    parameter logic [4:0] OP_DIVU  = 5'd19,
    parameter logic [4:0] OP_MTHI  = 5'd20,
    parameter logic [4:0] OP_MTLO  = 5'd21
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ex_busA,
    input  logic [31:0] ex_busB,
    input  logic [4:0]  ex_aluop,
    input  logic        md_flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall,
    output logic        md_busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;        // running product
    logic [63:0] mcand_q, mcand_d;    // multiplicand, shifted left each step
    logic [31:0] opb_q, opb_d;        // multiplier (shifted right) or divisor
    logic [31:0] quot_q, quot_d;      // dividend bits shift out, quotient bits shift in
    logic [31:0] rem_q, rem_d;        // partial remainder
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        busy_q;
    logic        stall_s;

    // Conditional two's-complement negate helpers for the final sign fix.
    function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    // Operand decode and magnitudes. Negating 0x80000000 yields the correct
    // unsigned magnitude.
    logic        is_mul_s, is_div_s, is_signed_s, a_neg_s, b_neg_s;
    logic [31:0] a_abs_s, b_abs_s;
    assign is_mul_s    = (ex_aluop == OP_MULT) || (ex_aluop == OP_MULTU);
    assign is_div_s    = (ex_aluop == OP_DIV) || (ex_aluop == OP_DIVU);
    assign is_signed_s = (ex_aluop == OP_MULT) || (ex_aluop == OP_DIV);
    assign a_neg_s     = is_signed_s & ex_busA[31];
    assign b_neg_s     = is_signed_s & ex_busB[31];
    assign a_abs_s     = cond_neg32(ex_busA, a_neg_s);
    assign b_abs_s     = cond_neg32(ex_busB, b_neg_s);

    // One multiply step, plus the signed 64-bit result used on the last step.
    logic [63:0] acc_next_s, prod_fix_s;
    assign acc_next_s = acc_q + (opb_q[0] ? mcand_q : 64'd0);
    assign prod_fix_s = cond_neg64(acc_next_s, neg_res_q);

    // One restoring-divide step. The trial subtraction is 33 bits wide
    // because the shifted partial remainder can reach 2*divisor-1.
    logic [32:0] diff_s;
    logic        fits_s;
    logic [31:0] rem_step_s, quot_step_s;
    assign diff_s      = {rem_q, quot_q[31]} - {1'b0, opb_q};
    assign fits_s      = ~diff_s[32];
    assign rem_step_s  = fits_s ? diff_s[31:0] : {rem_q[30:0], quot_q[31]};
    assign quot_step_s = {quot_q[30:0], fits_s};

    // Next-state, datapath update and stall request.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        count_d   = count_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        opb_d     = opb_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        stall_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (md_flush) begin
                    state_d = S_IDLE;
                end else if (is_mul_s) begin
                    stall_s   = 1'b1;
                    acc_d     = 64'd0;
                    mcand_d   = {32'd0, a_abs_s};
                    opb_d     = b_abs_s;
                    neg_res_d = a_neg_s ^ b_neg_s;
                    count_d   = 5'd31;
                    state_d   = S_MUL;
                end else if (is_div_s) begin
                    stall_s = 1'b1;
                    if (ex_busB == 32'd0) begin
                        // Divide by zero: fixed result, no iteration.
                        hi_d    = ex_busA;
                        lo_d    = 32'hFFFF_FFFF;
                        state_d = S_DONE;
                    end else begin
                        quot_d    = a_abs_s;
                        rem_d     = 32'd0;
                        opb_d     = b_abs_s;
                        neg_res_d = a_neg_s ^ b_neg_s;
                        neg_rem_d = a_neg_s;
                        count_d   = 5'd31;
                        state_d   = S_DIV;
                    end
                end else if (ex_aluop == OP_MTHI) begin
                    hi_d = ex_busA;
                end else if (ex_aluop == OP_MTLO) begin
                    lo_d = ex_busA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (md_flush) begin
                    state_d = S_IDLE;
                end else begin
                    stall_s = 1'b1;
                    acc_d   = acc_next_s;
                    mcand_d = {mcand_q[62:0], 1'b0};
                    opb_d   = {1'b0, opb_q[31:1]};
                    if (count_q == 5'd0) begin
                        {hi_d, lo_d} = prod_fix_s;
                        state_d      = S_DONE;
                    end else begin
                        count_d = count_q - 5'd1;
                    end
                end
            end
            S_DIV: begin
                if (md_flush) begin
                    state_d = S_IDLE;
                end else begin
                    stall_s = 1'b1;
                    rem_d   = rem_step_s;
                    quot_d  = quot_step_s;
                    if (count_q == 5'd0) begin
                        lo_d    = cond_neg32(quot_step_s, neg_res_q);
                        hi_d    = cond_neg32(rem_step_s, neg_rem_q);
                        state_d = S_DONE;
                    end else begin
                        count_d = count_q - 5'd1;
                    end
                end
            end
            S_DONE: begin
                // Result already committed; the instruction leaves EX now.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, HI/LO and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            count_q   <= 5'd0;
            acc_q     <= 64'd0;
            mcand_q   <= 64'd0;
            opb_q     <= 32'd0;
            quot_q    <= 32'd0;
            rem_q     <= 32'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            opb_q     <= opb_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= (state_d == S_MUL) || (state_d == S_DIV);
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign md_busy  = busy_q;
    // A pending start must not stall while reset is held.
    assign md_stall = rst_n & stall_s;

endmodule
